// File: rtl/memory_stage.sv
// Memory stage of the SEQ Y86-64 core: byte-addressed little-endian data
// memory with combinational reads, edge-triggered 8-byte writes, and the
// sticky processor status register that stops the machine on halt/error.
module memory_stage #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        imem_error,
    input  logic        func_error,
    output logic [63:0] valM,
    output logic [63:0] mem_addr,
    output logic        dmem_error,
    output logic [2:0]  stat,
    output logic        halted
);

    // Highest legal start address for an 8-byte access.
    localparam logic [63:0] LastAddr = 64'(DEPTH - 8);

    typedef enum logic [2:0] {
        StAok = 3'd1,
        StHlt = 3'd2,
        StAdr = 3'd3,
        StIns = 3'd4
    } stat_e;

    stat_e       r_stat;
    logic [7:0]  r_mem [DEPTH];

    logic        w_rd;
    logic        w_wr;
    logic        w_wr_en;
    logic [63:0] w_wdata;
    logic [AW-1:0] w_base;

    // Decode access type, effective address and write data from icode.
    always_comb begin
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        mem_addr = '0;
        w_wdata  = valA;
        case (icode)
            4'h4: begin mem_addr = valE; w_wr = 1'b1; end               // rmmovq
            4'h5: begin mem_addr = valE; w_rd = 1'b1; end               // mrmovq
            4'h8: begin mem_addr = valE; w_wr = 1'b1; w_wdata = valP; end // call
            4'hA: begin mem_addr = valE; w_wr = 1'b1; end               // pushq
            4'h9: begin mem_addr = valA; w_rd = 1'b1; end               // ret
            4'hB: begin mem_addr = valA; w_rd = 1'b1; end               // popq
            default: ;
        endcase
    end

    // Range check on the full 64-bit address, then combinational read.
    always_comb begin
        dmem_error = (w_rd || w_wr) && (mem_addr > LastAddr);
        w_base     = mem_addr[AW-1:0];
        valM       = '0;
        if (w_rd && !dmem_error) begin
            for (int i = 0; i < 8; i++) begin
                valM[8*i +: 8] = r_mem[w_base + AW'(i)];
            end
        end
    end

    // Status outputs and the write qualifier; faulting or stopped writes are dropped.
    always_comb begin
        stat    = r_stat;
        halted  = (r_stat != StAok);
        w_wr_en = w_wr && !dmem_error && !imem_error && !func_error && !halted;
    end

    // Data memory write; reset blocks the write but leaves contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_base + AW'(i)] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Sticky status FSM: leaves AOK on the first fault/halt and holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= StAok;
        end else if (r_stat == StAok) begin
            if (imem_error || dmem_error) begin
                r_stat <= StAdr;
            end else if (func_error) begin
                r_stat <= StIns;
            end else if (icode == 4'h0) begin
                r_stat <= StHlt;
            end
        end
    end

endmodule
